video_dma_write_feeder: RTL and testbench

- Upstream request generator for the AXI write-transaction engine in the video memory path.
- Takes a start command (base address, beat count) and an incoming pixel/data stream (valid/ready), and buffers beats in a small FIFO.
- Presents one write request at a time (addr, data, final_packet, data_avail) to the write engine and holds it until that engine returns a per-beat completion pulse.
- Signals done when the whole burst has been written.

---
 rtl/video_dma_write_feeder.sv | 164 ++++++++++++++++
 tb/tb_video_dma_write_feeder.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/video_dma_write_feeder.sv
// Write-request feeder: buffers stream beats and presents one write request at a time to the write engine.
// Optional abort/aborted ports are compiled in when VIDEO_DMA_ABORT_EN is defined.
`ifndef ROCKET_MEM_DAT_WIDTH
`define ROCKET_MEM_DAT_WIDTH 128
`endif

module video_dma_write_feeder #(
    parameter int LOWRISC_AXI_DATA_WIDTH = `ROCKET_MEM_DAT_WIDTH,
    parameter int VIDEOMEM_SIZE          = 18,
    parameter int LEN_WIDTH              = 16,
    parameter int FIFO_DEPTH             = 4
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              start,
    input  logic [VIDEOMEM_SIZE-1:0]          base_addr,
    input  logic [LEN_WIDTH-1:0]              len,
    output logic                              busy,
    output logic                              done,
`ifdef VIDEO_DMA_ABORT_EN
    input  logic                              abort,
    output logic                              aborted,
`endif
    input  logic                              s_valid,
    input  logic [LOWRISC_AXI_DATA_WIDTH-1:0] s_data,
    output logic                              s_ready,
    output logic                              wr_data_avail,
    output logic [VIDEOMEM_SIZE-1:0]          wr_addr,
    output logic [LOWRISC_AXI_DATA_WIDTH-1:0] wr_data,
    output logic                              wr_final_packet,
    input  logic                              wr_done
);

    localparam int BYTES = LOWRISC_AXI_DATA_WIDTH / 8;
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [VIDEOMEM_SIZE-1:0] ADDR_STEP = VIDEOMEM_SIZE'(BYTES);
    localparam logic [VIDEOMEM_SIZE-1:0] ADDR_MASK = ~VIDEOMEM_SIZE'(BYTES - 1);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

    state_t                            state;
    logic [VIDEOMEM_SIZE-1:0]          cur_addr;
    logic [LEN_WIDTH-1:0]              beats_in;
    logic [LEN_WIDTH-1:0]              beats_out;
    logic [LOWRISC_AXI_DATA_WIDTH-1:0] mem [FIFO_DEPTH];
    logic [PTR_W-1:0]                  rd_ptr;
    logic [PTR_W-1:0]                  wr_ptr;
    logic [CNT_W-1:0]                  count;
    logic                              push;
    logic                              pop;
    logic                              stream_open;

`ifdef VIDEO_DMA_ABORT_EN
    logic aborting;
    assign stream_open = !aborting;
`else
    assign stream_open = 1'b1;
`endif

    assign s_ready = busy && (count != CNT_W'(FIFO_DEPTH)) && (beats_in != '0) && stream_open;
    assign push    = s_valid && s_ready;
    // The head beat stays buffered until its write is acknowledged.
    assign pop     = (state == WAIT) && wr_done;

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= s_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state           <= IDLE;
            busy            <= 1'b0;
            done            <= 1'b0;
            cur_addr        <= '0;
            beats_in        <= '0;
            beats_out       <= '0;
            rd_ptr          <= '0;
            wr_ptr          <= '0;
            count           <= '0;
            wr_data_avail   <= 1'b0;
            wr_addr         <= '0;
            wr_data         <= '0;
            wr_final_packet <= 1'b0;
`ifdef VIDEO_DMA_ABORT_EN
            aborting        <= 1'b0;
            aborted         <= 1'b0;
`endif
        end else begin
            done <= 1'b0;
            if (push) begin
                wr_ptr   <= wr_ptr + PTR_W'(1);
                beats_in <= beats_in - LEN_WIDTH'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            count <= count + CNT_W'(push) - CNT_W'(pop);

            case (state)
                IDLE: begin
                    if (start) begin
                        cur_addr  <= base_addr & ADDR_MASK;
                        beats_in  <= len;
                        beats_out <= len;
                        busy      <= 1'b1;
                        state     <= (len == '0) ? DONE : ISSUE;
                    end
                end
                ISSUE: begin
                    if (count != '0) begin
                        wr_addr         <= cur_addr;
                        wr_data         <= mem[rd_ptr];
                        wr_final_packet <= (beats_out == LEN_WIDTH'(1));
                        wr_data_avail   <= 1'b1;
                        state           <= WAIT;
                    end
                end
                WAIT: begin
                    if (wr_done) begin
                        cur_addr        <= cur_addr + ADDR_STEP;
                        beats_out       <= beats_out - LEN_WIDTH'(1);
                        wr_data_avail   <= 1'b0;
                        wr_final_packet <= 1'b0;
                        state           <= (beats_out == LEN_WIDTH'(1)) ? DONE : ISSUE;
                    end
                end
                DONE: begin
                    done  <= 1'b1;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase

`ifdef VIDEO_DMA_ABORT_EN
            aborted <= 1'b0;
            if (state == DONE) begin
                aborted  <= aborting;
                aborting <= 1'b0;
            end
            // Abort flushes the buffer; an outstanding request still waits for its wr_done.
            if (abort && (state == ISSUE || state == WAIT)) begin
                aborting <= 1'b1;
                beats_in <= '0;
                count    <= '0;
                rd_ptr   <= '0;
                wr_ptr   <= '0;
                if (state == ISSUE) begin
                    wr_data_avail   <= 1'b0;
                    wr_final_packet <= 1'b0;
                    state           <= DONE;
                end
            end
            if (aborting && state == ISSUE) begin
                state <= DONE;
            end
`endif
        end
    end

endmodule

// File: tb/tb_video_dma_write_feeder.sv
// Self-checking bench for video_dma_write_feeder: table of commands, random bursts, and hand-written corner sequences.
module tb_video_dma_write_feeder;

    localparam int W  = 128;
    localparam int AW = 18;
    localparam int LW = 16;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic [AW-1:0] base_addr = '0;
    logic [LW-1:0] len = '0;
    logic          busy, done, s_ready, wr_data_avail, wr_final_packet;
    logic          s_valid = 1'b0;
    logic [W-1:0]  s_data = '0;
    logic [AW-1:0] wr_addr;
    logic [W-1:0]  wr_data;
    logic          wr_done = 1'b0;

    video_dma_write_feeder #(
        .LOWRISC_AXI_DATA_WIDTH(W), .VIDEOMEM_SIZE(AW), .LEN_WIDTH(LW), .FIFO_DEPTH(4)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .base_addr(base_addr), .len(len),
        .busy(busy), .done(done), .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready),
        .wr_data_avail(wr_data_avail), .wr_addr(wr_addr), .wr_data(wr_data),
        .wr_final_packet(wr_final_packet), .wr_done(wr_done)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Reference model state: what the current command should produce.
    logic [AW-1:0] exp_base_al;
    int            exp_len;
    int            req_idx;
    logic [W-1:0]  acc_q[$];
    logic [AW-1:0] first_a, last_a, cur_a;
    logic [W-1:0]  cur_d;
    bit            prev_avail = 1'b0;
    int            wait_cnt, done_cnt, wrdone_cnt;
    int            cyc = 0, start_cyc, done_cyc, last_wrdone_cyc;
    int            delay = 1;   // engine reply delay after request; -1 holds wr_done low
    int            vprob = 100; // percent chance of s_valid each cycle

    typedef struct {
        logic [AW-1:0] base;
        int            len;
        int            delay;
        int            vprob;
        logic [AW-1:0] first_addr;
        logic [AW-1:0] last_addr;
    } vec_t;

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        logic [AW-1:0] exp_a;
        logic [W-1:0]  exp_d;
        @(negedge clk);
        cyc++;
        if (done) begin
            done_cnt++;
            done_cyc = cyc;
        end
        if (wr_data_avail && !prev_avail) begin
            exp_a = exp_base_al + AW'(req_idx * 16);
            exp_d = (req_idx < acc_q.size()) ? acc_q[req_idx] : 'x;
            check("req_addr", wr_addr, exp_a);
            check("req_data", wr_data, exp_d);
            check("req_final", wr_final_packet, (req_idx == exp_len - 1));
            if (req_idx == 0) first_a = wr_addr;
            last_a = wr_addr;
            cur_a = wr_addr;
            cur_d = wr_data;
            req_idx++;
            wait_cnt = 0;
        end else if (wr_data_avail) begin
            check("req_hold", {wr_addr, wr_data}, {cur_a, cur_d});
        end
        prev_avail = wr_data_avail;
        wr_done = 1'b0;
        if (wr_data_avail && delay >= 0) begin
            if (wait_cnt >= delay) begin
                wr_done = 1'b1;
                wrdone_cnt++;
                last_wrdone_cyc = cyc;
            end
            wait_cnt++;
        end
        s_valid = ($urandom_range(99) < vprob);
        s_data  = {$urandom, $urandom, $urandom, $urandom};
        if (s_valid && s_ready) acc_q.push_back(s_data);
    endtask

    task automatic issue_start(input logic [AW-1:0] b, input int l);
        exp_base_al = b & ~AW'(15);
        exp_len     = l;
        req_idx     = 0;
        acc_q.delete();
        done_cnt    = 0;
        wrdone_cnt  = 0;
        first_a     = 'x;
        last_a      = 'x;
        check("idle_before_start", busy, 1'b0);
        start     = 1'b1;
        base_addr = b;
        len       = LW'(l);
        step();
        start = 1'b0;
        start_cyc = cyc;
        check("busy_after_start", busy, 1'b1);
        check("s_ready_after_start", s_ready, (l != 0));
    endtask

    task automatic finish_burst(input int budget);
        int n = 0;
        while (done_cnt == 0 && n < budget) begin
            step();
            n++;
        end
        check("done_seen", done_cnt, 1);
        check("requests_issued", req_idx, exp_len);
        check("beats_accepted", acc_q.size(), exp_len);
        if (exp_len > 0) check("done_latency", done_cyc, last_wrdone_cyc + 2);
        else             check("done_latency_zero", done_cyc, start_cyc + 1);
        step();
        check("busy_after_done", busy, 1'b0);
        check("done_one_cycle", {done, s_ready, wr_data_avail}, 3'b000);
        check("single_done", done_cnt, 1);
    endtask

    vec_t vecs[5];

    initial begin
        vecs[0] = '{18'h00100, 3, 2, 100, 18'h00100, 18'h00120};
        vecs[1] = '{18'h00000, 0, 1, 100, 18'h00000, 18'h00000};
        vecs[2] = '{18'h3FFF7, 2, 1, 100, 18'h3FFF0, 18'h00000};
        vecs[3] = '{18'h0ABCD, 5, 0,  60, 18'h0ABC0, 18'h0AC00};
        vecs[4] = '{18'h3FFE0, 4, 3,  40, 18'h3FFE0, 18'h00010};

        repeat (3) @(negedge clk);
        rst = 1'b0;
        check("reset_ctrl", {busy, done, s_ready, wr_data_avail, wr_final_packet}, 5'b0);
        check("reset_addr", wr_addr, '0);
        check("reset_data", wr_data, '0);

        for (int i = 0; i < 5; i++) begin
            delay = vecs[i].delay;
            vprob = vecs[i].vprob;
            issue_start(vecs[i].base, vecs[i].len);
            finish_burst(400);
            if (vecs[i].len > 0) begin
                check("vec_first_addr", first_a, vecs[i].first_addr);
                check("vec_last_addr", last_a, vecs[i].last_addr);
            end
        end

        // Backpressure: engine stalls, buffer fills to its depth, one completion frees one slot.
        delay = -1;
        vprob = 100;
        issue_start(18'h00000, 8);
        repeat (12) step();
        check("bp_accepted_full", acc_q.size(), 4);
        check("bp_s_ready_low", s_ready, 1'b0);
        check("bp_one_request", req_idx, 1);
        delay = 0;
        step();
        delay = -1;
        repeat (8) step();
        check("bp_one_more", acc_q.size(), 5);
        delay = 1;
        finish_burst(400);

        // Reset mid-burst: everything dropped, no done pulse, then a fresh command works.
        delay = 1;
        vprob = 100;
        issue_start(18'h00300, 5);
        for (int n = 0; n < 100 && wrdone_cnt < 2; n++) step();
        check("rst_two_wrdone", wrdone_cnt, 2);
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("rst_mid_ctrl", {busy, done, s_ready, wr_data_avail, wr_final_packet}, 5'b0);
        check("rst_mid_addr_data", {wr_addr, wr_data}, '0);
        repeat (4) step();
        check("rst_no_done", done_cnt, 0);
        issue_start(18'h00200, 1);
        finish_burst(100);
        check("rst_new_addr", first_a, 18'h00200);

        // A start while busy is ignored.
        delay = 1;
        issue_start(18'h00400, 2);
        step();
        start = 1'b1;
        base_addr = 18'h01000;
        len = LW'(2);
        step();
        start = 1'b0;
        finish_burst(200);
        check("ign_first_addr", first_a, 18'h00400);
        check("ign_last_addr", last_a, 18'h00410);
        repeat (4) step();
        check("ign_still_idle", {busy, done}, 2'b00);

        // Random commands against the arithmetic model.
        for (int i = 0; i < 20; i++) begin
            delay = $urandom_range(3);
            vprob = $urandom_range(100, 30);
            issue_start(AW'($urandom), $urandom_range(12, 1));
            finish_burst(800);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
